// File: rtl/kmcintr_pkg.sv
// kmcintr_pkg: shared types and constants for the KMC interrupt arbiter.
// State encoding, vector width and vector stride live here.
package kmcintr_pkg;

  localparam int VECT_W      = 9;
  localparam int VECT_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACT     = 2'd1,
    VECTCLR = 2'd2
  } kmc_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kmcintr_prio.sv
// kmcintr_prio: fixed-priority encoder, lowest set index wins.
// Index is meaningful only when valid_o is high.
module kmcintr_prio
  import kmcintr_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top so the lowest requesting index is the final write.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/kmc_intr_arb.sv
// kmc_intr_arb: PDP-11 style interrupt arbiter for the KMC channels.
// Define KMCINTR_OVRN_EN to add the per-channel kmcOVRN overrun flags.
module kmc_intr_arb
  import kmcintr_pkg::*;
#(
  parameter int                 NCHAN    = 2,
  parameter logic [VECT_W-1:0]  VECTBASE = 9'o300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kmcINIT,
  input  logic [NCHAN-1:0]  kmcSETIRQ,
  input  logic [NCHAN-1:0]  kmcIENA,
  input  logic              kmcIACK,
  output logic              kmcIRQO,
  output logic [VECT_W-1:0] kmcVECT,
`ifdef KMCINTR_OVRN_EN
  output logic [NCHAN-1:0]  kmcOVRN,
`endif
  output logic [NCHAN-1:0]  kmcPEND
);

  localparam int IW = idx_w(NCHAN);

  kmc_state_e        state_q;
  logic [IW-1:0]     grant_q;
  logic              irq_q;
  logic [VECT_W-1:0] vect_q;
  logic [NCHAN-1:0]  pend_q, pend_d;
  logic [NCHAN-1:0]  req;
  logic [NCHAN-1:0]  clr_mask;
  logic              win_v;
  logic [IW-1:0]     win_idx;

  // Requests: latched or just-arriving strobes, gated by enable.
  always_comb begin
    req      = (pend_q | kmcSETIRQ) & kmcIENA;
    clr_mask = '0;
    if (state_q == ACT && kmcIACK) clr_mask[grant_q] = 1'b1;
    pend_d   = (pend_q & ~clr_mask) | kmcSETIRQ;
  end

  kmcintr_prio #(
    .N  (NCHAN),
    .IW (IW)
  ) u_prio (
    .req_i   (req),
    .valid_o (win_v),
    .idx_o   (win_idx)
  );

  // Pending flags; a strobe on the clearing edge keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pend_q <= '0;
    else if (kmcINIT) pend_q <= '0;
    else              pend_q <= pend_d;
  end

`ifdef KMCINTR_OVRN_EN
  logic [NCHAN-1:0] ovrn_q;

  // Sticky overrun: strobe while already pending, except on its clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovrn_q <= '0;
    else if (kmcINIT) ovrn_q <= '0;
    else              ovrn_q <= ovrn_q | (kmcSETIRQ & pend_q & ~clr_mask);
  end

  assign kmcOVRN = ovrn_q;
`endif

  // Handshake FSM; grant and vector frozen from ACT until back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      irq_q   <= 1'b0;
      vect_q  <= VECTBASE;
    end else if (kmcINIT) begin
      state_q <= IDLE;
      grant_q <= '0;
      irq_q   <= 1'b0;
      vect_q  <= VECTBASE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_v) begin
            state_q <= ACT;
            grant_q <= win_idx;
            irq_q   <= 1'b1;
            vect_q  <= VECTBASE
                     + VECT_W'(VECT_STRIDE) * VECT_W'(win_idx);
          end
        end
        ACT: begin
          if (kmcIACK) state_q <= VECTCLR;
        end
        VECTCLR: begin
          if (!kmcIACK) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            vect_q  <= VECTBASE;
          end
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
          vect_q  <= VECTBASE;
        end
      endcase
    end
  end

  assign kmcIRQO = irq_q;
  assign kmcVECT = vect_q;
  assign kmcPEND = pend_q;

endmodule

// File: tb/tb_kmc_intr_arb.sv
// tb_kmc_intr_arb: self-checking bench for kmc_intr_arb (NCHAN=2).
// Granted vectors are queued as expected and popped on each IRQO rise.
module tb_kmc_intr_arb;

  localparam int NCHAN = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             kmcINIT = 1'b0;
  logic [NCHAN-1:0] kmcSETIRQ = '0;
  logic [NCHAN-1:0] kmcIENA = '1;
  logic             kmcIACK = 1'b0;
  logic             kmcIRQO;
  logic [8:0]       kmcVECT;
  logic [NCHAN-1:0] kmcPEND;
`ifdef KMCINTR_OVRN_EN
  logic [NCHAN-1:0] kmcOVRN;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] exp_q[$];
  logic       prev_irq = 1'b0;

  kmc_intr_arb #(
    .NCHAN    (NCHAN),
    .VECTBASE (9'o300)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kmcINIT   (kmcINIT),
    .kmcSETIRQ (kmcSETIRQ),
    .kmcIENA   (kmcIENA),
    .kmcIACK   (kmcIACK),
    .kmcIRQO   (kmcIRQO),
    .kmcVECT   (kmcVECT),
`ifdef KMCINTR_OVRN_EN
    .kmcOVRN   (kmcOVRN),
`endif
    .kmcPEND   (kmcPEND)
  );

  always #5 clk = ~clk;

  // Scoreboard: each new request must carry the oldest queued vector.
  always @(negedge clk) begin
    if (!rst && kmcIRQO && !prev_irq) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected: vect=%o queued=none", kmcVECT);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if (kmcVECT !== e) begin
          mismatched++;
          $display("FAIL sb_vect: got %o want %o", kmcVECT, e);
        end
      end
    end
    prev_irq = kmcIRQO;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic handshake();
    kmcIACK = 1'b1;
    repeat (3) tick();
    kmcIACK = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    compared++;
    if (kmcIRQO !== 1'b0 || kmcVECT !== 9'o300 || kmcPEND !== 2'b00) begin
      mismatched++;
      $display("FAIL reset: irq=%b vect=%o pend=%b want 0/300/00",
               kmcIRQO, kmcVECT, kmcPEND);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    kmcSETIRQ = 2'b01;
    exp_q.push_back(9'o300);
    tick();
    kmcSETIRQ = 2'b00;
    compared++;
    if (kmcIRQO !== 1'b1 || kmcVECT !== 9'o300) begin
      mismatched++;
      $display("FAIL single_req: irq=%b vect=%o want 1/300",
               kmcIRQO, kmcVECT);
    end
    kmcIACK = 1'b1;
    repeat (3) tick();
    compared++;
    if (kmcIRQO !== 1'b1 || kmcPEND !== 2'b00) begin
      mismatched++;
      $display("FAIL single_iack: irq=%b pend=%b want 1/00",
               kmcIRQO, kmcPEND);
    end
    kmcIACK = 1'b0;
    tick();
    compared++;
    if (kmcIRQO !== 1'b0 || kmcPEND !== 2'b00 || kmcVECT !== 9'o300) begin
      mismatched++;
      $display("FAIL single_done: irq=%b pend=%b vect=%o want 0/00/300",
               kmcIRQO, kmcPEND, kmcVECT);
    end
  endtask

  task automatic test_back_to_back();
    kmcSETIRQ = 2'b11;
    exp_q.push_back(9'o300);
    exp_q.push_back(9'o304);
    tick();
    kmcSETIRQ = 2'b00;
    compared++;
    if (kmcVECT !== 9'o300 || kmcPEND !== 2'b11) begin
      mismatched++;
      $display("FAIL b2b_first: vect=%o pend=%b want 300/11",
               kmcVECT, kmcPEND);
    end
    handshake();
    compared++;
    if (kmcIRQO !== 1'b0 || kmcPEND !== 2'b10) begin
      mismatched++;
      $display("FAIL b2b_gap: irq=%b pend=%b want 0/10", kmcIRQO, kmcPEND);
    end
    tick();
    compared++;
    if (kmcIRQO !== 1'b1 || kmcVECT !== 9'o304) begin
      mismatched++;
      $display("FAIL b2b_second: irq=%b vect=%o want 1/304",
               kmcIRQO, kmcVECT);
    end
    handshake();
    compared++;
    if (kmcIRQO !== 1'b0 || kmcPEND !== 2'b00) begin
      mismatched++;
      $display("FAIL b2b_done: irq=%b pend=%b want 0/00", kmcIRQO, kmcPEND);
    end
  endtask

  task automatic test_no_preempt();
    kmcSETIRQ = 2'b10;
    exp_q.push_back(9'o304);
    tick();
    kmcSETIRQ = 2'b01;
    exp_q.push_back(9'o300);
    tick();
    kmcSETIRQ = 2'b00;
    tick();
    compared++;
    if (kmcVECT !== 9'o304 || kmcPEND !== 2'b11) begin
      mismatched++;
      $display("FAIL nopre_hold: vect=%o pend=%b want 304/11",
               kmcVECT, kmcPEND);
    end
    kmcIACK = 1'b1;
    tick();
    compared++;
    if (kmcVECT !== 9'o304 || kmcIRQO !== 1'b1) begin
      mismatched++;
      $display("FAIL nopre_iack: vect=%o irq=%b want 304/1",
               kmcVECT, kmcIRQO);
    end
    repeat (2) tick();
    kmcIACK = 1'b0;
    tick();
    tick();
    compared++;
    if (kmcIRQO !== 1'b1 || kmcVECT !== 9'o300) begin
      mismatched++;
      $display("FAIL nopre_next: irq=%b vect=%o want 1/300",
               kmcIRQO, kmcVECT);
    end
    handshake();
  endtask

  task automatic test_enable();
    kmcIENA   = 2'b01;
    kmcSETIRQ = 2'b10;
    tick();
    kmcSETIRQ = 2'b00;
    tick();
    compared++;
    if (kmcIRQO !== 1'b0 || kmcPEND !== 2'b10) begin
      mismatched++;
      $display("FAIL ena_masked: irq=%b pend=%b want 0/10",
               kmcIRQO, kmcPEND);
    end
    kmcIENA = 2'b11;
    exp_q.push_back(9'o304);
    tick();
    kmcIENA = 2'b00;
    tick();
    compared++;
    if (kmcIRQO !== 1'b1 || kmcVECT !== 9'o304) begin
      mismatched++;
      $display("FAIL ena_kept: irq=%b vect=%o want 1/304",
               kmcIRQO, kmcVECT);
    end
    handshake();
    kmcIENA = 2'b11;
    compared++;
    if (kmcIRQO !== 1'b0 || kmcPEND !== 2'b00) begin
      mismatched++;
      $display("FAIL ena_done: irq=%b pend=%b want 0/00", kmcIRQO, kmcPEND);
    end
  endtask

  task automatic test_set_on_clear();
    kmcSETIRQ = 2'b01;
    exp_q.push_back(9'o300);
    tick();
    kmcSETIRQ = 2'b01;
    kmcIACK   = 1'b1;
    exp_q.push_back(9'o300);
    tick();
    kmcSETIRQ = 2'b00;
    compared++;
    if (kmcPEND !== 2'b01) begin
      mismatched++;
      $display("FAIL soc_pend: pend=%b want 01", kmcPEND);
    end
`ifdef KMCINTR_OVRN_EN
    compared++;
    if (kmcOVRN !== 2'b00) begin
      mismatched++;
      $display("FAIL soc_ovrn: ovrn=%b want 00", kmcOVRN);
    end
`endif
    tick();
    kmcIACK = 1'b0;
    tick();
    compared++;
    if (kmcIRQO !== 1'b0 || kmcPEND !== 2'b01) begin
      mismatched++;
      $display("FAIL soc_gap: irq=%b pend=%b want 0/01", kmcIRQO, kmcPEND);
    end
    tick();
    compared++;
    if (kmcIRQO !== 1'b1 || kmcVECT !== 9'o300) begin
      mismatched++;
      $display("FAIL soc_again: irq=%b vect=%o want 1/300",
               kmcIRQO, kmcVECT);
    end
    handshake();
  endtask

  task automatic test_overrun();
    kmcIENA   = 2'b00;
    kmcSETIRQ = 2'b01;
    tick();
    kmcSETIRQ = 2'b00;
    tick();
    kmcSETIRQ = 2'b01;
    tick();
    kmcSETIRQ = 2'b00;
    tick();
    compared++;
    if (kmcPEND !== 2'b01 || kmcIRQO !== 1'b0) begin
      mismatched++;
      $display("FAIL ovr_merge: pend=%b irq=%b want 01/0", kmcPEND, kmcIRQO);
    end
`ifdef KMCINTR_OVRN_EN
    compared++;
    if (kmcOVRN !== 2'b01) begin
      mismatched++;
      $display("FAIL ovr_flag: ovrn=%b want 01", kmcOVRN);
    end
`endif
    kmcINIT = 1'b1;
    tick();
    kmcINIT = 1'b0;
    kmcIENA = 2'b11;
    tick();
    compared++;
    if (kmcPEND !== 2'b00 || kmcIRQO !== 1'b0) begin
      mismatched++;
      $display("FAIL ovr_init: pend=%b irq=%b want 00/0", kmcPEND, kmcIRQO);
    end
`ifdef KMCINTR_OVRN_EN
    compared++;
    if (kmcOVRN !== 2'b00) begin
      mismatched++;
      $display("FAIL ovr_clr: ovrn=%b want 00", kmcOVRN);
    end
`endif
  endtask

  task automatic test_async_reset();
    kmcSETIRQ = 2'b10;
    exp_q.push_back(9'o304);
    tick();
    kmcSETIRQ = 2'b00;
    compared++;
    if (kmcIRQO !== 1'b1 || kmcVECT !== 9'o304) begin
      mismatched++;
      $display("FAIL arst_pre: irq=%b vect=%o want 1/304", kmcIRQO, kmcVECT);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (kmcIRQO !== 1'b0 || kmcPEND !== 2'b00 || kmcVECT !== 9'o300) begin
      mismatched++;
      $display("FAIL arst_now: irq=%b pend=%b vect=%o want 0/00/300",
               kmcIRQO, kmcPEND, kmcVECT);
    end
    #1 rst = 1'b0;
    tick();
    kmcIACK = 1'b1;
    repeat (2) tick();
    kmcIACK = 1'b0;
    repeat (2) tick();
    compared++;
    if (kmcIRQO !== 1'b0 || kmcPEND !== 2'b00 || kmcVECT !== 9'o300) begin
      mismatched++;
      $display("FAIL arst_iack: irq=%b pend=%b vect=%o want 0/00/300",
               kmcIRQO, kmcPEND, kmcVECT);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_no_preempt();
    test_enable();
    test_set_on_clear();
    test_overrun();
    test_async_reset();
    repeat (2) tick();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL sb_leftover: queued=%0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/kmc_intr_arb.md
KMC_INTR_ARB -- requirements
Module: kmc_intr_arb

Interface
REQ-001 SHALL provide parameter: NCHAN, 2, number of interrupt channels (1..8).
REQ-002 SHALL provide parameter: VECTBASE, 9'o300, PDP-11 vector of channel 0.
REQ-003 SHALL provide port: clk  input  1  clock, the single clock domain.
REQ-004 SHALL provide port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port: kmcINIT  input  1  synchronous initialize.
REQ-006 SHALL provide port: kmcSETIRQ  input  NCHAN  per-channel interrupt set strobe, one bit per channel, one cycle wide.
REQ-007 SHALL provide port: kmcIENA  input  NCHAN  per-channel interrupt enable.
REQ-008 SHALL provide port: kmcIACK  input  1  interrupt acknowledge, level.
REQ-009 SHALL provide port: kmcIRQO  output  1  interrupt request out.
REQ-010 SHALL provide port: kmcVECT  output  9  vector of the granted channel.
REQ-011 SHALL provide port: kmcPEND  output  NCHAN  pending flags, readable status.

Function
REQ-012 SHALL keep pend[i], set at the clock edge sampling kmcSETIRQ[i]=1, held until its vector cycle completes.
REQ-013 SHALL define req = (pend | kmcSETIRQ) & kmcIENA; lowest index wins (fixed priority).
REQ-014 SHALL use state machine IDLE, ACT, VECTCLR; kmcIRQO = (state != IDLE), registered.
REQ-015 SHALL go IDLE->ACT when req != 0, latching grant = highest-priority index in the same edge.
REQ-016 SHALL give one-cycle latency: SETIRQ sampled at edge n with IENA=1 and state IDLE -> kmcIRQO=1 after edge n.
REQ-017 SHALL go ACT->VECTCLR on kmcIACK=1 and clear pend[grant] on that edge.
REQ-018 SHALL go VECTCLR->IDLE on kmcIACK=0; kmcIRQO SHALL drop on the edge IACK is seen low, never during IACK.
REQ-019 SHALL hold grant and kmcVECT stable from entry to ACT until return to IDLE; new higher-priority requests SHALL NOT preempt.
REQ-020 SHALL drive kmcVECT = VECTBASE + 4*grant, 9-bit, modulo 512; kmcVECT = VECTBASE in IDLE.
REQ-021 SHALL let SETIRQ[grant] on the clearing edge win: pend[grant] stays set, giving a new request after IDLE.
REQ-022 SHALL keep pending flags with IENA=0 latched but not arbitrated; clearing IENA while in ACT SHALL NOT withdraw the request.
REQ-023 SHALL re-arbitrate from IDLE with no extra delay cycle; back-to-back channels SHALL each get one request.

Reset
REQ-024 SHALL on rst (async) or kmcINIT (sync) force state=IDLE, pend=0, grant=0, kmcIRQO=0, kmcVECT=VECTBASE, overrun flags=0.
REQ-025 SHALL on reset mid-handshake (ACT/VECTCLR) abandon the cycle; a later IACK SHALL be ignored.

Configuration
REQ-026 SHALL, with KMCINTR_OVRN_EN defined, add output kmcOVRN[NCHAN]: set when SETIRQ[i] arrives while pend[i]=1 (not on the clearing edge), cleared only by reset/kmcINIT.
REQ-027 SHALL, without KMCINTR_OVRN_EN, omit kmcOVRN and its logic; a duplicate SETIRQ is silently merged.

Structure
REQ-028 SHALL place the state enum (IDLE/ACT/VECTCLR), vector width (9), and vector stride (4) in package kmcintr_pkg.
REQ-029 SHALL implement the priority encoder as sub-module kmcintr_prio (NCHAN request in -> valid + index out).

Verification
REQ-030 SHALL cover: NCHAN=2, SETIRQ=01, IENA=11 -> IRQO=1 next cycle, VECT=0300; IACK high 3 cycles then low -> IRQO=0 after IACK low, PEND=00.
REQ-031 SHALL cover: SETIRQ=11 same cycle -> VECT=0300 first; after handshake, IRQO reasserts next cycle with VECT=0304.
REQ-032 SHALL cover: channel 1 granted, then SETIRQ=01 during ACT -> VECT stays 0304 until IDLE, then 0300 served.
REQ-033 SHALL cover: SETIRQ=10 with IENA=01 -> IRQO=0, PEND=10; set IENA=11 -> IRQO=1, VECT=0304.
REQ-034 SHALL cover: SETIRQ[0] on IACK edge -> PEND[0] stays 1, second request follows; with KMCINTR_OVRN_EN, SETIRQ=01 twice while pending -> OVRN=01.
REQ-035 SHALL cover: rst pulsed asynchronously in ACT -> IRQO=0, PEND=0 immediately; following IACK pulse -> no state change.
